riscv_hazard_ctrl: RTL and testbench
====================================

// Module: riscv_hazard_ctrl
// PURPOSE
//  Parametrised pipeline-control unit for the in-order RISC-V core.
//  Tracks in-flight destination registers from EX to WB and generates load-use stalls, branch flushes and EX operand
//  forward selects. Drains and halts the pipeline on a halt micro-op.
//  Sits beside the ID stage; its outputs drive the PC/IF-ID write enables, ID/EX bubble insertion and the EX operand muxes.
// PARAMETERS
//  RA_W   5   register-address width
//  DEPTH  3   tracked stages after ID (0=EX, 1=MEM, ..., DEPTH-1=WB); DEPTH>=2
//  CNT_W  32  retired-instruction counter width
//  FWD_W  $clog2(DEPTH)  forward-select width (localparam)
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      asynchronous, active-low reset (asserted when 0)
//  id_valid       in   1      ID holds a real instruction
//  id_rs1/id_rs2  in   RA_W   ID source addresses
//  id_use_rs1/2   in   1      ID instruction reads that source
//  id_rd          in   RA_W   ID destination
//  id_rd_wr_en    in   1      ID instruction writes id_rd
//  id_is_load     in   1      ID instruction is a load
//  id_halt        in   1      ID instruction is halt
//  ex_branch_taken in  1      EX branch resolved taken this cycle
//  stall_f        out  1      hold PC and IF/ID (comb)
//  flush_d        out  1      clear IF/ID to bubble (comb)
//  bubble_e       out  1      load ID/EX with bubble instead of ID (comb)
//  wb_byp_a/b_d   out  1      ID reads rs1/rs2 from RD_DATA, not regfile (comb)
//  fwd_a_e/fwd_b_e out FWD_W  registered EX operand select: 0=ID/EX data, k=result of stage k (1=MEM..DEPTH-1=WB)
//  ohalt          out  1      pipeline fully drained after halt (registered)
//  retired        out  CNT_W  count of retired non-halt instructions (registered, wraps)
// BEHAVIOUR
//  - Tracker entry {valid, rd, wr_en, is_load, halt} per stage.
//  - match(j,s,use) = ent[j].valid & ent[j].wr_en & ent[j].rd==s & s!=0 & use.
//  - Load-use: match(0,rs,use) & ent[0].is_load for either source -> stall_f=1, bubble_e=1, flush_d=0 (ID held).
//  - Branch: ex_branch_taken -> flush_d=1, bubble_e=1, stall_f=0.
//    Branch overrides simultaneous load-use stall and halt in ID.
//  - Every edge: ent[j+1]<=ent[j].
//    ent[0]<=ID fields if id_valid & !bubble_e & state==RUN, else invalid.
//    Stages EX..WB never stall.
//  - Fwd select, computed at ID, latched into fwd_*_e on the same edge as ent[0]:
//    youngest-first, first j in 0..DEPTH-2 with match(j) -> j+1, else 0.
//    Forced 0 when ent[0] is loaded invalid.
//  - ID bypass: wb_byp_x_d = match(DEPTH-1, id_rsx, id_use_rsx); the regfile gives no write-through.
//  - FSM RUN/DRAIN/HALTED:
//    RUN->DRAIN on edge where a halt enters ent[0].
//    DRAIN: stall_f=1, flush_d=1, bubble_e=1.
//    DRAIN->HALTED on edge where ent[DEPTH-1].halt. HALTED: ohalt=1, stall_f=flush_d=bubble_e=1, sticky until reset.
//  - retired += 1 on each edge with ent[DEPTH-1].valid & !ent[DEPTH-1].halt.
//  - Reset (async, any time): entries invalid, fwd_*_e=0, state RUN, ohalt=0, retired=0.
//    Comb outputs drop to 0 immediately.
//  - x0 never matches; valid=0 entries never match; halt entries have wr_en=0.
// STRUCTURE
//  - riscv_pkg: hz_entry_t struct, hz_state_e enum {RUN,DRAIN,HALTED}, FWD_NONE=0 constant.
//  - Sub-module hz_tracker: DEPTH-entry shift register of hz_entry_t with async active-low reset.
//  - Top holds the match logic, FSM, forward registers and counter.
// TESTING
//  - add x5 then add x6,x5,x1 back-to-back -> consumer in EX sees fwd_a_e=1, no stall.
//  - lw x7 then add x8,x7,x7 -> one cycle of stall_f=bubble_e=1, then fwd_a_e=fwd_b_e=2.
//  - addi x9, two NOPs, then use x9 in ID while producer in WB -> wb_byp_a_d=1; writes to x0 never forward.
//  - beq taken in EX while lw-use stall pending -> flush_d=bubble_e=1, stall_f=0; the next 2 ent[0] are invalid.
//  - 4 adds, halt -> ohalt rises exactly DEPTH edges after halt enters EX; retired=4; PC held thereafter.
//  - rst low mid-DRAIN -> ohalt=0, fwd=0, retired=0 without a clock; normal execution on release.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types for the pipeline hazard controller
package riscv_pkg;

    // Upper bound on register-address width; entries zero-extend narrower addresses.
    localparam int RD_W = 8;
    localparam int FWD_NONE = 0;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            wr_en;
        logic            is_load;
        logic            halt;
    } hz_entry_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hz_state_e;

endpackage

// File: rtl/riscv_hazard_ctrl_if.sv
// rtl/riscv_hazard_ctrl_if.sv - ID-side request and pipeline-control signals of the hazard controller
interface riscv_hazard_ctrl_if #(
    parameter int RA_W  = 5,
    parameter int DEPTH = 3,
    parameter int CNT_W = 32
);
    localparam int FWD_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             id_valid;
    logic [RA_W-1:0]  id_rs1;
    logic [RA_W-1:0]  id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [RA_W-1:0]  id_rd;
    logic             id_rd_wr_en;
    logic             id_is_load;
    logic             id_halt;
    logic             ex_branch_taken;
    logic             stall_f;
    logic             flush_d;
    logic             bubble_e;
    logic             wb_byp_a_d;
    logic             wb_byp_b_d;
    logic [FWD_W-1:0] fwd_a_e;
    logic [FWD_W-1:0] fwd_b_e;
    logic             ohalt;
    logic [CNT_W-1:0] retired;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_wr_en,
               id_is_load, id_halt, ex_branch_taken,
        input  stall_f, flush_d, bubble_e, wb_byp_a_d, wb_byp_b_d, fwd_a_e, fwd_b_e,
               ohalt, retired
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_wr_en,
               id_is_load, id_halt, ex_branch_taken,
        output stall_f, flush_d, bubble_e, wb_byp_a_d, wb_byp_b_d, fwd_a_e, fwd_b_e,
               ohalt, retired
    );

endinterface

// File: rtl/hz_tracker.sv
// rtl/hz_tracker.sv - shift register of in-flight destination entries, EX through WB
module hz_tracker
    import riscv_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic      clk,
    input  logic      rst,
    input  hz_entry_t ent_in,
    output hz_entry_t ent [DEPTH]
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                ent[j] <= '0;
            end
        end else begin
            ent[0] <= ent_in;
            for (int j = 1; j < DEPTH; j++) begin
                ent[j] <= ent[j-1];
            end
        end
    end

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// rtl/riscv_hazard_ctrl.sv - load-use stall, branch flush, forwarding and halt-drain control
module riscv_hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int RA_W  = 5,
    parameter int DEPTH = 3,
    parameter int CNT_W = 32
) (
    input logic               clk,
    input logic               rst,
    riscv_hazard_ctrl_if.slave hz
);

    localparam int FWD_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    hz_entry_t        ent [DEPTH];
    hz_entry_t        ent_in;
    hz_state_e        state, state_nxt;
    logic             load_use, load_en;
    logic             stall_f, flush_d, bubble_e;
    logic [FWD_W-1:0] fwd_a, fwd_b, fwd_a_nxt, fwd_b_nxt;
    logic [CNT_W-1:0] ret_cnt;

    hz_tracker #(.DEPTH(DEPTH)) u_tracker (
        .clk    (clk),
        .rst    (rst),
        .ent_in (ent_in),
        .ent    (ent)
    );

    function automatic logic match(input hz_entry_t e, input logic [RA_W-1:0] s, input logic use_s);
        return e.valid & e.wr_en & (e.rd == RD_W'(s)) & (s != '0) & use_s;
    endfunction

    // Scan oldest to youngest so the youngest matching producer wins.
    function automatic logic [FWD_W-1:0] fwd_sel(input logic [RA_W-1:0] s, input logic use_s);
        logic [FWD_W-1:0] sel;
        sel = FWD_W'(FWD_NONE);
        for (int j = DEPTH - 2; j >= 0; j--) begin
            if (match(ent[j], s, use_s)) sel = FWD_W'(j + 1);
        end
        return sel;
    endfunction

    always_comb begin
        stall_f  = 1'b0;
        flush_d  = 1'b0;
        bubble_e = 1'b0;
        load_use = ent[0].is_load &
                   (match(ent[0], hz.id_rs1, hz.id_use_rs1) | match(ent[0], hz.id_rs2, hz.id_use_rs2));
        if (!rst) begin
            stall_f = 1'b0;
        end else if (state != RUN) begin
            stall_f  = 1'b1;
            flush_d  = 1'b1;
            bubble_e = 1'b1;
        end else if (hz.ex_branch_taken) begin
            flush_d  = 1'b1;
            bubble_e = 1'b1;
        end else if (load_use) begin
            stall_f  = 1'b1;
            bubble_e = 1'b1;
        end
    end

    always_comb begin
        load_en   = hz.id_valid & ~bubble_e & (state == RUN);
        ent_in    = '0;
        fwd_a_nxt = FWD_W'(FWD_NONE);
        fwd_b_nxt = FWD_W'(FWD_NONE);
        if (load_en) begin
            ent_in.valid   = 1'b1;
            ent_in.rd      = RD_W'(hz.id_rd);
            ent_in.wr_en   = hz.id_rd_wr_en & ~hz.id_halt;
            ent_in.is_load = hz.id_is_load;
            ent_in.halt    = hz.id_halt;
            fwd_a_nxt      = fwd_sel(hz.id_rs1, hz.id_use_rs1);
            fwd_b_nxt      = fwd_sel(hz.id_rs2, hz.id_use_rs2);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (load_en & hz.id_halt) state_nxt = DRAIN;
            DRAIN:   if (ent[DEPTH-1].halt) state_nxt = HALTED;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            fwd_a   <= FWD_W'(FWD_NONE);
            fwd_b   <= FWD_W'(FWD_NONE);
            ret_cnt <= '0;
        end else begin
            state <= state_nxt;
            fwd_a <= fwd_a_nxt;
            fwd_b <= fwd_b_nxt;
            if (ent[DEPTH-1].valid & ~ent[DEPTH-1].halt) ret_cnt <= ret_cnt + CNT_W'(1);
        end
    end

    assign hz.stall_f    = stall_f;
    assign hz.flush_d    = flush_d;
    assign hz.bubble_e   = bubble_e;
    assign hz.wb_byp_a_d = rst & match(ent[DEPTH-1], hz.id_rs1, hz.id_use_rs1);
    assign hz.wb_byp_b_d = rst & match(ent[DEPTH-1], hz.id_rs2, hz.id_use_rs2);
    assign hz.fwd_a_e    = fwd_a;
    assign hz.fwd_b_e    = fwd_b;
    assign hz.ohalt      = (state == HALTED);
    assign hz.retired    = ret_cnt;

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// tb/tb_riscv_hazard_ctrl.sv - self-checking bench for riscv_hazard_ctrl
module tb_riscv_hazard_ctrl;

    localparam int RA_W  = 5;
    localparam int DEPTH = 3;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    riscv_hazard_ctrl_if #(.RA_W(RA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) hz ();

    riscv_hazard_ctrl #(.RA_W(RA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
        bit hl;
    } m_ent_t;

    // Reference pipeline: slot k holds the instruction now in stage k; mode 0=run 1=drain 2=halted.
    m_ent_t    mp [DEPTH];
    int        m_mode;
    int        m_fa, m_fb;
    bit [31:0] m_ret;
    bit        e_stall, e_flush, e_bub, e_ba, e_bb;

    bit i_v, i_wr, i_u1, i_u2, i_ld, i_hl, i_br;
    int i_rd, i_rs1, i_rs2;

    int checks = 0;
    int errs   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit mm(int j, int s, bit u);
        return mp[j].v && mp[j].wr && mp[j].rd == s && s != 0 && u;
    endfunction

    function automatic int m_fwd(int s, bit u);
        for (int j = 0; j <= DEPTH - 2; j++) if (mm(j, s, u)) return j + 1;
        return 0;
    endfunction

    task automatic m_reset();
        for (int j = 0; j < DEPTH; j++) mp[j] = '{default: 0};
        m_mode = 0; m_fa = 0; m_fb = 0; m_ret = 0;
    endtask

    task automatic model_comb();
        bit lu;
        lu = mp[0].ld && (mm(0, i_rs1, i_u1) || mm(0, i_rs2, i_u2));
        e_stall = (m_mode != 0) || (!i_br && lu);
        e_flush = (m_mode != 0) || i_br;
        e_bub   = (m_mode != 0) || i_br || lu;
        e_ba    = mm(DEPTH - 1, i_rs1, i_u1);
        e_bb    = mm(DEPTH - 1, i_rs2, i_u2);
    endtask

    task automatic model_edge();
        bit loaded;
        loaded = i_v && !e_bub && m_mode == 0;
        m_fa = loaded ? m_fwd(i_rs1, i_u1) : 0;
        m_fb = loaded ? m_fwd(i_rs2, i_u2) : 0;
        if (mp[DEPTH-1].v && !mp[DEPTH-1].hl) m_ret = m_ret + 1;
        if (m_mode == 1 && mp[DEPTH-1].v && mp[DEPTH-1].hl) m_mode = 2;
        else if (m_mode == 0 && loaded && i_hl) m_mode = 1;
        for (int j = DEPTH - 1; j > 0; j--) mp[j] = mp[j-1];
        if (loaded) mp[0] = '{v: 1, rd: i_rd, wr: i_wr && !i_hl, ld: i_ld, hl: i_hl};
        else        mp[0] = '{default: 0};
    endtask

    task automatic issue(bit v, int rd, bit wr, int rs1, bit u1, int rs2, bit u2, bit ld, bit hl, bit br);
        i_v = v; i_rd = rd; i_wr = wr; i_rs1 = rs1; i_u1 = u1; i_rs2 = rs2; i_u2 = u2;
        i_ld = ld; i_hl = hl; i_br = br;
        hz.id_valid = v; hz.id_rd = RA_W'(rd); hz.id_rd_wr_en = wr;
        hz.id_rs1 = RA_W'(rs1); hz.id_use_rs1 = u1; hz.id_rs2 = RA_W'(rs2); hz.id_use_rs2 = u2;
        hz.id_is_load = ld; hz.id_halt = hl; hz.ex_branch_taken = br;
    endtask

    task automatic nop();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        #1;
        model_comb();
        chk("stall_f", hz.stall_f, e_stall);
        chk("flush_d", hz.flush_d, e_flush);
        chk("bubble_e", hz.bubble_e, e_bub);
        chk("wb_byp_a_d", hz.wb_byp_a_d, e_ba);
        chk("wb_byp_b_d", hz.wb_byp_b_d, e_bb);
        @(posedge clk);
        model_edge();
        #1;
        chk("fwd_a_e", hz.fwd_a_e, m_fa);
        chk("fwd_b_e", hz.fwd_b_e, m_fb);
        chk("ohalt", hz.ohalt, m_mode == 2);
        chk("retired", hz.retired, m_ret);
    endtask

    // Asserts reset between edges and checks outputs before any clock arrives.
    task automatic do_reset();
        rst = 1'b0;
        #2;
        chk("rst_ohalt", hz.ohalt, 0);
        chk("rst_fwd_a", hz.fwd_a_e, 0);
        chk("rst_fwd_b", hz.fwd_b_e, 0);
        chk("rst_retired", hz.retired, 0);
        chk("rst_stall_f", hz.stall_f, 0);
        chk("rst_flush_d", hz.flush_d, 0);
        chk("rst_bubble_e", hz.bubble_e, 0);
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        m_reset();
        nop();
        @(posedge clk);
        #1;
        do_reset();

        // add x5; add x6,x5,x1 -> EX forward from MEM
        issue(1, 5, 1, 1, 1, 2, 1, 0, 0, 0); step();
        issue(1, 6, 1, 5, 1, 1, 1, 0, 0, 0); step();
        chk("t1_fwd_a", hz.fwd_a_e, 1);
        nop(); step(); step();

        // lw x7; add x8,x7,x7 -> one stall then forward from WB
        issue(1, 7, 1, 1, 1, 0, 0, 1, 0, 0); step();
        issue(1, 8, 1, 7, 1, 7, 1, 0, 0, 0);
        #1;
        chk("t2_stall", hz.stall_f, 1);
        chk("t2_bubble", hz.bubble_e, 1);
        step();
        chk("t2_held_fwd", hz.fwd_a_e, 0);
        step();
        chk("t2_fwd_a", hz.fwd_a_e, 2);
        chk("t2_fwd_b", hz.fwd_b_e, 2);
        nop(); step(); step(); step();

        // addi x9, two bubbles, use x9 while producer sits in WB; x0 producer never forwards
        issue(1, 9, 1, 0, 0, 0, 0, 0, 0, 0); step();
        nop(); step(); step();
        issue(1, 10, 1, 9, 1, 3, 1, 0, 0, 0);
        #1;
        chk("t3_byp_a", hz.wb_byp_a_d, 1);
        chk("t3_byp_b", hz.wb_byp_b_d, 0);
        step();
        issue(1, 0, 1, 1, 1, 1, 1, 0, 0, 0); step();
        issue(1, 11, 1, 0, 1, 0, 1, 0, 0, 0); step();
        chk("t3_x0_fwd", hz.fwd_a_e, 0);
        nop(); step(); step(); step();

        // taken branch in EX overrides a pending load-use stall
        issue(1, 7, 1, 1, 1, 0, 0, 1, 0, 0); step();
        issue(1, 8, 1, 7, 1, 0, 0, 0, 0, 1);
        #1;
        chk("t4_flush", hz.flush_d, 1);
        chk("t4_stall", hz.stall_f, 0);
        step();
        nop(); step();
        issue(1, 12, 1, 7, 1, 0, 0, 0, 0, 0); step();
        chk("t4_fwd_none", hz.fwd_a_e, 0);
        nop(); step(); step(); step();

        // 4 adds then halt: ohalt rises DEPTH edges after halt enters EX
        do_reset();
        for (int k = 0; k < 4; k++) begin
            issue(1, 13 + k, 1, 1, 1, 2, 1, 0, 0, 0); step();
        end
        issue(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); step();
        issue(1, 20, 1, 1, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k < DEPTH; k++) begin
            step();
            chk("t5_ohalt_early", hz.ohalt, 0);
        end
        step();
        chk("t5_ohalt", hz.ohalt, 1);
        chk("t5_retired", hz.retired, 4);
        step();
        chk("t5_pc_held", hz.stall_f, 1);

        // reset in the middle of a drain, then resume
        do_reset();
        for (int k = 0; k < 3; k++) begin
            issue(1, 21 + k, 1, 1, 1, 0, 0, 0, 0, 0); step();
        end
        issue(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); step();
        nop(); step();
        do_reset();
        issue(1, 5, 1, 1, 1, 2, 1, 0, 0, 0); step();
        issue(1, 6, 1, 5, 1, 5, 1, 0, 0, 0); step();
        chk("t6_fwd_a", hz.fwd_a_e, 1);
        chk("t6_fwd_b", hz.fwd_b_e, 1);

        // random traffic over a small register set to provoke hazards
        for (int n = 0; n < 400; n++) begin
            issue($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0);
            step();
            if (m_mode == 2 || $urandom_range(0, 99) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
